// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: the mul/div op encoding (also used by the ALU control decode)
// and the state encoding of the iterative multiply/divide unit.
package mips_cpu_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FIXUP = 2'd2
   } muldiv_state_t;

   function automatic logic op_is_signed(input muldiv_op_t op);
      return (op == MULT) || (op == DIV);
   endfunction

   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/mips_cpu_divstep.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift the quotient bit in.
module mips_cpu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   assign shifted = {rem_i, quo_i[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr};
   assign fits    = (shifted >= {1'b0, dvsr});

   always_comb begin
      if (fits) begin
         rem_o = diff[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, STEPS bits per ITER cycle.
// Define MIPS_MULDIV_EARLY_TERM_EN to let multiplies finish once the multiplier is exhausted.
module mips_cpu_muldiv_iter
   import mips_cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N  = WIDTH / STEPS;
   localparam int CW = $clog2(N + 1);

   muldiv_state_t state, state_nxt;
   muldiv_op_t    op_in, op_q;
   logic [CW-1:0] cnt;
   logic          neg_q, neg_r;
   logic          a_neg, b_neg, last_iter;

   logic [2*WIDTH-1:0] prod, prod_nxt, mcand, mcand_nxt, prod_fix;
   logic [WIDTH-1:0]   mplier, mplier_nxt;
   logic [WIDTH-1:0]   rem, quo, dvsr;
   logic [WIDTH-1:0]   a_abs, b_abs, hi_res, lo_res;
   logic [STEPS:0][WIDTH-1:0] rem_c, quo_c;

   assign op_in = muldiv_op_t'(op);
   assign a_neg = op_is_signed(op_in) & a[WIDTH-1];
   assign b_neg = op_is_signed(op_in) & b[WIDTH-1];
   assign a_abs = a_neg ? -a : a;
   assign b_abs = b_neg ? -b : b;
   assign busy  = (state != IDLE);

   // NOTE: blocking assignments here chain the STEPS shift-add steps within one cycle.
   always_comb begin
      prod_nxt   = prod;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      for (int i = 0; i < STEPS; i++) begin
         if (mplier_nxt[0]) prod_nxt = prod_nxt + mcand_nxt;
         mcand_nxt  = mcand_nxt << 1;
         mplier_nxt = mplier_nxt >> 1;
      end
   end

   assign rem_c[0] = rem;
   assign quo_c[0] = quo;
   for (genvar g = 0; g < STEPS; g++) begin : g_divstep
      mips_cpu_divstep #(.WIDTH(WIDTH)) u_divstep (
         .rem_i (rem_c[g]),
         .quo_i (quo_c[g]),
         .dvsr  (dvsr),
         .rem_o (rem_c[g+1]),
         .quo_o (quo_c[g+1])
      );
   end

`ifdef MIPS_MULDIV_EARLY_TERM_EN
   assign last_iter = (cnt == CW'(N - 1)) || (!op_is_div(op_q) && (mplier_nxt == '0));
`else
   assign last_iter = (cnt == CW'(N - 1));
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = ITER;
         ITER:    if (last_iter) state_nxt = FIXUP;
         FIXUP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A zero divisor leaves the dividend magnitude in rem, so re-signing it returns a.
   always_comb begin
      prod_fix = neg_q ? -prod : prod;
      hi_res   = prod_fix[2*WIDTH-1:WIDTH];
      lo_res   = prod_fix[WIDTH-1:0];
      if (op_is_div(op_q)) begin
         hi_res = neg_r ? -rem : rem;
         lo_res = (dvsr == '0) ? '1 : (neg_q ? -quo : quo);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  cnt      <= '0;
                  div_zero <= 1'b0;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            ITER: cnt <= cnt + CW'(1);
            FIXUP: begin
               hi       <= hi_res;
               lo       <= lo_res;
               done     <= 1'b1;
               div_zero <= op_is_div(op_q) && (dvsr == '0);
            end
            default: ;
         endcase
      end
   end

   // NOTE: operand/accumulator registers carry no reset; the start edge always loads them before use.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         op_q   <= op_in;
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         prod   <= '0;
         mcand  <= {{WIDTH{1'b0}}, a_abs};
         mplier <= b_abs;
         rem    <= '0;
         quo    <= a_abs;
         dvsr   <= b_abs;
      end else if (state == ITER) begin
         prod   <= prod_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         rem    <= rem_c[STEPS];
         quo    <= quo_c[STEPS];
      end
   end

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
// Self-checking bench: STEPS=1 and STEPS=4 instances share stimulus and are compared
// against a plain-arithmetic reference for results, latency and handshake behaviour.
module tb_mips_cpu_muldiv_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, hi_we, lo_we;
   logic [1:0]   op;
   logic [W-1:0] a, b, wdata;
   logic         busy1, done1, dz1, busy4, done4, dz4;
   logic [W-1:0] hi1, lo1, hi4, lo4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mips_cpu_muldiv_iter #(.WIDTH(W), .STEPS(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1)
   );

   mips_cpu_muldiv_iter #(.WIDTH(W), .STEPS(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy4), .done(done4), .div_zero(dz4), .hi(hi4), .lo(lo4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference result {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
      logic [63:0] p;
      int          sx, sy;
      sx = x;
      sy = y;
      case (o)
         2'd0: p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
         2'd1: p = {32'd0, x} * {32'd0, y};
         2'd2: begin
            if (y == 0)                                  p = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == '1)      p = {32'd0, 32'h8000_0000};
            else                                         p = {32'(sx % sy), 32'(sx / sy)};
         end
         default: begin
            if (y == 0) p = {x, 32'hFFFF_FFFF};
            else        p = {x % y, x / y};
         end
      endcase
      return p;
   endfunction

   // Edges from start to done for a unit handling `steps` bits per cycle.
   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y, input int steps);
      int          k;
      logic [31:0] mag;
      k   = 32 / steps;
      mag = y;
`ifdef MIPS_MULDIV_EARLY_TERM_EN
      if (!o[1]) begin
         if (o == 2'd0 && y[31]) mag = -y;
         k = 0;
         while (mag != 0 && k < 32 / steps) begin
            mag = mag >> steps;
            k++;
         end
         if (k == 0) k = 1;
      end
`else
      if (o[1] && mag == 0) k = 32 / steps;
`endif
      return k + 1;
   endfunction

   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke, input bit wr_at_start);
      logic [63:0] exp;
      logic [31:0] hi1_0, lo1_0, hi4_0, lo4_0;
      int          lat1, lat4, nd1, nd4;
      bit          hold1, hold4, ovl;
      exp   = ref_result(o, x, y);
      hi1_0 = hi1; lo1_0 = lo1; hi4_0 = hi4; lo4_0 = lo4;
      lat1  = 0; lat4 = 0; nd1 = 0; nd4 = 0;
      hold1 = 1'b1; hold4 = 1'b1; ovl = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (wr_at_start) begin
         hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      @(negedge clk);
      check("dz_clear1", dz1, 0);
      check("dz_clear4", dz4, 0);
      a = $urandom; b = $urandom; lo_we = 1'b0;
      for (int c = 0; c <= 40; c++) begin
         if (done1) begin nd1++; if (lat1 == 0) lat1 = c; end
         if (done4) begin nd4++; if (lat4 == 0) lat4 = c; end
         if (lat1 == 0 && (!busy1 || hi1 != hi1_0 || lo1 != lo1_0)) hold1 = 1'b0;
         if (lat4 == 0 && (!busy4 || hi4 != hi4_0 || lo4 != lo4_0)) hold4 = 1'b0;
         if ((done1 && busy1) || (done4 && busy4)) ovl = 1'b1;
         start = (c == poke);
         hi_we = (c == poke);
         if (c == poke) begin
            op = 2'($urandom); wdata = 32'h1234_5678;
         end
         @(negedge clk);
      end
      start = 1'b0; hi_we = 1'b0;
      check("latency1", lat1, exp_lat(o, y, 1));
      check("latency4", lat4, exp_lat(o, y, 4));
      check("hi1", hi1, exp[63:32]);
      check("lo1", lo1, exp[31:0]);
      check("hi4", hi4, exp[63:32]);
      check("lo4", lo4, exp[31:0]);
      check("div_zero1", dz1, o[1] && y == 0);
      check("div_zero4", dz4, o[1] && y == 0);
      check("done_count1", nd1, 1);
      check("done_count4", nd4, 1);
      check("busy_hold1", hold1, 1);
      check("busy_hold4", hold4, 1);
      check("done_busy_overlap", ovl, 0);
   endtask

   initial begin
      int nd;
      logic [1:0]  o;
      logic [31:0] x, y;
      reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'd0; a = '0; b = '0; wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {busy1, busy4}, 0);
      check("rst_done", {done1, done4}, 0);
      check("rst_dz", {dz1, dz4}, 0);
      check("rst_hilo1", {hi1, lo1}, 0);
      check("rst_hilo4", {hi4, lo4}, 0);
      reset = 1'b1;

      do_op(2'd0, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
      do_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
      do_op(2'd3, 32'd100, 32'd0, -1, 1'b0);
      do_op(2'd2, 32'hFFFF_FF00, 32'd0, -1, 1'b0);
      do_op(2'd3, 32'd1000, 32'd7, 5, 1'b0);
      do_op(2'd1, 32'd5, 32'd3, -1, 1'b1);

      // MTHI / MTLO in IDLE
      @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk); hi_we = 1'b0;
      check("mthi1", hi1, 32'h1234_5678);
      check("mthi4", hi4, 32'h1234_5678);
      check("mthi_lo_keep", lo1, 32'h0000_000F);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      check("mthilo1", {hi1, lo1}, {32'hCAFE_F00D, 32'hCAFE_F00D});
      check("mthilo4", {hi4, lo4}, {32'hCAFE_F00D, 32'hCAFE_F00D});

      // Reset in the middle of a DIV abandons it
      start = 1'b1; op = 2'd2; a = 32'd77; b = 32'd5;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", {busy1, busy4}, 0);
      check("midrst_done", {done1, done4}, 0);
      check("midrst_hilo1", {hi1, lo1}, 0);
      check("midrst_hilo4", {hi4, lo4}, 0);
      reset = 1'b1;
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         nd += int'(done1) + int'(done4);
      end
      check("midrst_no_done", nd, 0);

      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = '0;
            1: y = '1;
            2: x = 32'h8000_0000;
            3: y = $urandom_range(1, 15);
            default: ;
         endcase
         do_op(o, x, y, (o[1] && $urandom_range(0, 1) == 1) ? 3 : -1, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
